vpu_dst_port: RTL and testbench
===============================

VPU_DST_PORT -- requirements
Module: vpu_dst_port

Interface
REQ-001 The block SHALL have no module parameters; all widths and counts SHALL come from VPU_PKG.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  controller pulse that opens one writeback operation.
REQ-006 dst_addr_i  input  OPERAND_ADDR_WIDTH  destination SRAM word address; sampled when start_i is accepted.
REQ-007 wb_valid_i  input  1  VLANE result beat valid.
REQ-008 wb_data_i  input  EXEC_UNIT_DATA_WIDTH  VLANE result beat.
REQ-009 wb_ready_o  output  1  block can accept a result beat.
REQ-010 done_o  output  1  one-cycle pulse: SRAM write of the operation completed.
REQ-011 sram_wren_o  output  1  SRAM write request.
REQ-012 sram_waddr_o  output  OPERAND_ADDR_WIDTH  SRAM write address.
REQ-013 sram_wdata_o  output  SRAM_DATA_WIDTH  SRAM write data (packed word).
REQ-014 sram_wready_i  input  1  SRAM accepts the write in any cycle where sram_wren_o=1.

Function
REQ-015 The FSM SHALL have states IDLE, COLLECT, WRITE and DONE.
REQ-016 IDLE: start_i=1 SHALL latch dst_addr_i, clear the beat counter to 0 and move to COLLECT.
- start_i SHALL be ignored in every state other than IDLE.
REQ-017 wb_ready_o SHALL be 1 only in COLLECT.
- A beat SHALL be accepted only when wb_valid_i=1 and wb_ready_o=1 in the same cycle.
- wb_valid_i outside COLLECT SHALL have no effect.
REQ-018 Accepted beat k (k=0..EXEC_CNT-1) SHALL be written to pack-buffer bits [k*EXEC_UNIT_DATA_WIDTH +: EXEC_UNIT_DATA_WIDTH].
- Bits not written in the current operation SHALL hold their previous values.
REQ-019 The beat counter (EXEC_CNT_LG2 bits) SHALL increment by 1 per accepted beat.
- Acceptance at count EXEC_CNT-1 SHALL move to WRITE and wrap the counter to 0.
REQ-020 Latency: if the last beat is accepted in cycle N, sram_wren_o SHALL be 1 from cycle N+1.
REQ-021 In WRITE, sram_wren_o SHALL be 1 and sram_waddr_o and sram_wdata_o SHALL stay stable until sram_wready_i=1.
- The state SHALL then move to DONE.
REQ-022 sram_wren_o SHALL be 0 in IDLE, COLLECT and DONE.
- Outside WRITE, sram_waddr_o and sram_wdata_o SHALL hold the latched address and the pack buffer.
REQ-023 DONE SHALL last exactly one cycle, with done_o=1, then return to IDLE.
- done_o SHALL be 0 in all other states.
REQ-024 If sram_wready_i is 1 in the first WRITE cycle, the write SHALL complete in that cycle; there is no minimum wait.
REQ-025 sram_wready_i SHALL be ignored whenever sram_wren_o=0.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately, in any state including mid-operation:
- force IDLE
- clear the counter, the pack buffer and the latched address to 0
- drive wb_ready_o, done_o and sram_wren_o to 0.
REQ-027 After rst_n deasserts, the block SHALL accept nothing until the next start_i.

Structure
REQ-028 VPU_PKG SHALL hold SRAM_DATA_WIDTH, EXEC_UNIT_DATA_WIDTH, EXEC_CNT (=SRAM_DATA_WIDTH/EXEC_UNIT_DATA_WIDTH), EXEC_CNT_LG2, OPERAND_ADDR_WIDTH and the enum dst_port_state_t.
REQ-029 One sub-module, vpu_dst_port_controller, SHALL hold the FSM and the SRAM write handshake.
- The pack buffer and the beat counter SHALL stay in vpu_dst_port.
REQ-030 Beat ordering SHALL be the inverse of the source-port unpacking: beat 0 is the low slice.

Verification (EXEC_CNT=2)
REQ-031 Basic write:
- Stimulus: start_i with addr 0x10; beats 0xAAAA.., 0x5555..; sram_wready_i tied 1.
- Response: a single write to 0x10 of word {0x5555..,0xAAAA..}; done_o pulses 2 cycles after the last beat.
REQ-032 SRAM backpressure:
- Stimulus: sram_wready_i low for 5 cycles in WRITE.
- Response: sram_wren_o, sram_waddr_o and sram_wdata_o stay stable for 5 cycles; done_o stays 0 until the cycle after acceptance.
REQ-033 Gapped beats and out-of-window beats:
- Stimulus: beats driven with 3 idle cycles between them; wb_valid_i=1 asserted in IDLE and in WRITE.
- Response: no extra beats are captured; the packed word is correct.
REQ-034 start_i while busy:
- Stimulus: start_i with addr 0x20 during COLLECT and during WRITE.
- Response: both are ignored; the write goes to the original address.
REQ-035 Mid-operation reset:
- Stimulus: rst_n=0 after beat 0.
- Response: outputs go to 0 at once; a new operation to 0x30 then writes only its own two beats correctly.
REQ-036 Back-to-back operations:
- Stimulus: start_i in the first IDLE cycle after DONE.
- Response: accepted; two writes and two done_o pulses in order.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared widths and the destination-port FSM state type for the VPU writeback path.
package vpu_pkg;

   localparam int unsigned SRAM_DATA_WIDTH      = 128;
   localparam int unsigned EXEC_UNIT_DATA_WIDTH = 64;
   localparam int unsigned EXEC_CNT             = SRAM_DATA_WIDTH / EXEC_UNIT_DATA_WIDTH;
   // Keep the counter at least one bit wide even for a single-beat word.
   localparam int unsigned EXEC_CNT_LG2         = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;
   localparam int unsigned OPERAND_ADDR_WIDTH   = 10;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StWrite,
      StDone
   } dst_port_state_t;

endpackage

// File: rtl/vpu_dst_port_controller.sv
// Sequencing FSM for the destination port: opens an operation, collects beats,
// holds the SRAM write request until accepted, then pulses done for one cycle.
module vpu_dst_port_controller
   import vpu_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   input  logic last_beat_i,
   input  logic sram_wready_i,
   output logic start_ack_o,
   output logic wb_ready_o,
   output logic sram_wren_o,
   output logic done_o
);

   dst_port_state_t state_q, state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      start_ack_o = 1'b0;
      wb_ready_o  = 1'b0;
      sram_wren_o = 1'b0;
      done_o      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               start_ack_o = 1'b1;
               state_d     = StCollect;
            end
         end
         StCollect: begin
            wb_ready_o = 1'b1;
            if (last_beat_i) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            sram_wren_o = 1'b1;
            if (sram_wready_i) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: rtl/vpu_dst_port.sv
// VPU destination port: packs EXEC_CNT lane result beats (beat 0 = low slice)
// into one SRAM word and writes it to the address latched at start.
module vpu_dst_port
   import vpu_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start_i,
   input  logic [OPERAND_ADDR_WIDTH-1:0]   dst_addr_i,
   input  logic                            wb_valid_i,
   input  logic [EXEC_UNIT_DATA_WIDTH-1:0] wb_data_i,
   output logic                            wb_ready_o,
   output logic                            done_o,
   output logic                            sram_wren_o,
   output logic [OPERAND_ADDR_WIDTH-1:0]   sram_waddr_o,
   output logic [SRAM_DATA_WIDTH-1:0]      sram_wdata_o,
   input  logic                            sram_wready_i
);

   logic [EXEC_CNT_LG2-1:0]       cnt_q, cnt_d;
   logic [SRAM_DATA_WIDTH-1:0]    buf_q, buf_d;
   logic [OPERAND_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                          start_ack;
   logic                          beat_acc;
   logic                          last_beat;

   assign beat_acc  = wb_valid_i & wb_ready_o;
   assign last_beat = beat_acc && (cnt_q == EXEC_CNT_LG2'(EXEC_CNT - 1));

   vpu_dst_port_controller u_ctrl (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .last_beat_i   (last_beat),
      .sram_wready_i (sram_wready_i),
      .start_ack_o   (start_ack),
      .wb_ready_o    (wb_ready_o),
      .sram_wren_o   (sram_wren_o),
      .done_o        (done_o)
   );

   always_comb begin
      cnt_d  = cnt_q;
      addr_d = addr_q;
      buf_d  = buf_q;
      if (start_ack) begin
         cnt_d  = '0;
         addr_d = dst_addr_i;
      end else if (beat_acc) begin
         cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      end
      // Only the slice selected by the counter changes; the rest keeps its old contents.
      for (int unsigned k = 0; k < EXEC_CNT; k++) begin
         if (beat_acc && (cnt_q == EXEC_CNT_LG2'(k))) begin
            buf_d[k*EXEC_UNIT_DATA_WIDTH +: EXEC_UNIT_DATA_WIDTH] = wb_data_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         addr_q <= '0;
         buf_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         buf_q  <= buf_d;
      end
   end

   // No beat can be accepted in WRITE, so these are stable while the request is held.
   assign sram_waddr_o = addr_q;
   assign sram_wdata_o = buf_q;

endmodule

// File: tb/tb_vpu_dst_port.sv
// Randomized bench for vpu_dst_port against a transaction-level packing model.
module tb_vpu_dst_port;
   import vpu_pkg::*;

   localparam int unsigned AW = OPERAND_ADDR_WIDTH;
   localparam int unsigned EW = EXEC_UNIT_DATA_WIDTH;
   localparam int unsigned SW = SRAM_DATA_WIDTH;
   localparam logic [AW-1:0] BUSY_ADDR = AW'(32'h20);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i;
   logic [AW-1:0] dst_addr_i;
   logic          wb_valid_i;
   logic [EW-1:0] wb_data_i;
   logic          wb_ready_o;
   logic          done_o;
   logic          sram_wren_o;
   logic [AW-1:0] sram_waddr_o;
   logic [SW-1:0] sram_wdata_o;
   logic          sram_wready_i;

   int checks = 0;
   int errors = 0;
   int writes_seen = 0;
   int dones_seen = 0;
   int writes_exp = 0;
   int dones_exp = 0;

   // Model: the packed word as an array of lane slices, plus the beats of the next op.
   logic [EW-1:0] mbuf [EXEC_CNT];
   logic [EW-1:0] next_beats [EXEC_CNT];

   vpu_dst_port dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .dst_addr_i    (dst_addr_i),
      .wb_valid_i    (wb_valid_i),
      .wb_data_i     (wb_data_i),
      .wb_ready_o    (wb_ready_o),
      .done_o        (done_o),
      .sram_wren_o   (sram_wren_o),
      .sram_waddr_o  (sram_waddr_o),
      .sram_wdata_o  (sram_wdata_o),
      .sram_wready_i (sram_wready_i)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && sram_wren_o && sram_wready_i) writes_seen <= writes_seen + 1;
      if (rst_n && done_o) dones_seen <= dones_seen + 1;
   end

   task automatic check_eq(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SW-1:0] model_word();
      logic [SW-1:0] w;
      w = '0;
      for (int k = 0; k < EXEC_CNT; k++) w[k*EW +: EW] = mbuf[k];
      return w;
   endfunction

   task automatic rand_beats();
      for (int k = 0; k < EXEC_CNT; k++) next_beats[k] = {$urandom, $urandom};
   endtask

   task automatic run_op(input logic [AW-1:0] addr, input int gap, input int wait_cyc,
                         input bit noise);
      logic [SW-1:0] exp;
      if (noise) begin
         wb_valid_i = 1'b1;
         wb_data_i  = {$urandom, $urandom};
         tick();
         check_eq("idle_no_ready", SW'(wb_ready_o), '0);
         wb_valid_i = 1'b0;
      end
      check_eq("idle_wren", SW'(sram_wren_o), '0);
      start_i    = 1'b1;
      dst_addr_i = addr;
      tick();
      start_i    = 1'b0;
      dst_addr_i = AW'($urandom);
      for (int k = 0; k < EXEC_CNT; k++) begin
         for (int g = 0; g < gap; g++) begin
            wb_valid_i    = 1'b0;
            sram_wready_i = 1'($urandom);
            if (noise) begin
               start_i    = 1'b1;
               dst_addr_i = BUSY_ADDR;
            end
            tick();
            start_i = 1'b0;
         end
         check_eq("collect_ready", SW'(wb_ready_o), SW'(1));
         sram_wready_i = 1'($urandom);
         wb_valid_i    = 1'b1;
         wb_data_i     = next_beats[k];
         mbuf[k]       = next_beats[k];
         tick();
         wb_valid_i = 1'b0;
      end
      exp = model_word();
      check_eq("write_wren", SW'(sram_wren_o), SW'(1));
      check_eq("write_addr", SW'(sram_waddr_o), SW'(addr));
      check_eq("write_data", sram_wdata_o, exp);
      check_eq("write_ready_low", SW'(wb_ready_o), '0);
      for (int d = 0; d < wait_cyc; d++) begin
         sram_wready_i = 1'b0;
         if (noise) begin
            wb_valid_i = 1'b1;
            wb_data_i  = {$urandom, $urandom};
            start_i    = 1'b1;
            dst_addr_i = BUSY_ADDR;
         end
         tick();
         wb_valid_i = 1'b0;
         start_i    = 1'b0;
         check_eq("bp_wren", SW'(sram_wren_o), SW'(1));
         check_eq("bp_addr", SW'(sram_waddr_o), SW'(addr));
         check_eq("bp_data", sram_wdata_o, exp);
         check_eq("bp_done", SW'(done_o), '0);
      end
      sram_wready_i = 1'b1;
      tick();
      writes_exp++;
      dones_exp++;
      check_eq("done_pulse", SW'(done_o), SW'(1));
      check_eq("done_wren", SW'(sram_wren_o), '0);
      check_eq("done_data", sram_wdata_o, exp);
      sram_wready_i = 1'($urandom);
      tick();
      check_eq("idle_done", SW'(done_o), '0);
      check_eq("idle_ready", SW'(wb_ready_o), '0);
   endtask

   initial begin
      rst_n         = 1'b0;
      start_i       = 1'b0;
      dst_addr_i    = '0;
      wb_valid_i    = 1'b0;
      wb_data_i     = '0;
      sram_wready_i = 1'b0;
      for (int k = 0; k < EXEC_CNT; k++) mbuf[k] = '0;
      tick();
      tick();
      check_eq("rst_ready", SW'(wb_ready_o), '0);
      check_eq("rst_done", SW'(done_o), '0);
      check_eq("rst_wren", SW'(sram_wren_o), '0);
      check_eq("rst_addr", SW'(sram_waddr_o), '0);
      check_eq("rst_data", sram_wdata_o, '0);
      rst_n = 1'b1;
      tick();

      // Basic write with alternating patterns, no backpressure.
      for (int k = 0; k < EXEC_CNT; k++)
         next_beats[k] = (k % 2 == 0) ? {EW/2{2'b10}} : {EW/2{2'b01}};
      run_op(AW'(32'h10), 0, 0, 1'b0);

      // SRAM backpressure for 5 cycles.
      rand_beats();
      run_op(AW'(32'h11), 0, 5, 1'b0);

      // Gapped beats, stray valids and busy starts.
      rand_beats();
      run_op(AW'(32'h12), 3, 3, 1'b1);

      // Mid-operation reset after beat 0.
      start_i    = 1'b1;
      dst_addr_i = AW'(32'h44);
      tick();
      start_i    = 1'b0;
      wb_valid_i = 1'b1;
      wb_data_i  = {$urandom, $urandom};
      tick();
      wb_valid_i = 1'b0;
      rst_n      = 1'b0;
      #1;
      for (int k = 0; k < EXEC_CNT; k++) mbuf[k] = '0;
      check_eq("mid_rst_ready", SW'(wb_ready_o), '0);
      check_eq("mid_rst_wren", SW'(sram_wren_o), '0);
      check_eq("mid_rst_done", SW'(done_o), '0);
      check_eq("mid_rst_addr", SW'(sram_waddr_o), '0);
      check_eq("mid_rst_data", sram_wdata_o, '0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wb_valid_i = 1'b1;
         wb_data_i  = {$urandom, $urandom};
         tick();
         check_eq("post_rst_ready", SW'(wb_ready_o), '0);
      end
      wb_valid_i = 1'b0;
      rand_beats();
      run_op(AW'(32'h30), 0, 0, 1'b0);

      // Back-to-back and randomized operations.
      for (int i = 0; i < 12; i++) begin
         rand_beats();
         run_op(AW'($urandom), $urandom_range(0, 3), $urandom_range(0, 5), 1'($urandom));
      end

      tick();
      check_eq("write_count", SW'(writes_seen), SW'(writes_exp));
      check_eq("done_count", SW'(dones_seen), SW'(dones_exp));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
